control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 70 +++++++
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit_reg_select.sv | 15 +
 rtl/control_unit.sv | 196 +++++++++++++++++++
 tb/tb_control_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : opcodes, control-step states and bit maps for control_unit |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [4:0] ADD  = 5'd0,  SUB  = 5'd1,  AND  = 5'd2,  OR   = 5'd3;
  localparam logic [4:0] SHR  = 5'd4,  SHL  = 5'd5,  ROR  = 5'd6,  ROL  = 5'd7;
  localparam logic [4:0] ADDI = 5'd8,  ANDI = 5'd9,  ORI  = 5'd10, LD   = 5'd11;
  localparam logic [4:0] LDI  = 5'd12, ST   = 5'd13, MUL  = 5'd14, DIV  = 5'd15;
  localparam logic [4:0] NEG  = 5'd16, NOT  = 5'd17, JR   = 5'd20, MFHI = 5'd22;
  localparam logic [4:0] MFLO = 5'd23, IN   = 5'd24, OUT  = 5'd25, NOP  = 5'd26;
  localparam logic [4:0] HALT = 5'd27, INC  = 5'd31;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_LD, CLS_ST,
    CLS_UNARY, CLS_SINGLE, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  localparam int BUS_HI     = 16;
  localparam int BUS_LO     = 17;
  localparam int BUS_ZHI    = 18;
  localparam int BUS_ZLO    = 19;
  localparam int BUS_PC     = 20;
  localparam int BUS_MDR    = 21;
  localparam int BUS_INPORT = 22;
  localparam int BUS_C      = 23;

  localparam int CTRL_IRIN   = 0;
  localparam int CTRL_PCIN   = 1;
  localparam int CTRL_RYIN   = 2;
  localparam int CTRL_RZIN   = 3;
  localparam int CTRL_MARIN  = 4;
  localparam int CTRL_MDRIN  = 5;
  localparam int CTRL_HIIN   = 6;
  localparam int CTRL_LOIN   = 7;
  localparam int CTRL_OUTIN  = 8;
  localparam int CTRL_INPIN  = 9;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      ADD, SUB, AND, OR, SHR, SHL, ROR, ROL: return CLS_RTYPE;
      ADDI, ANDI, ORI, LDI:                  return CLS_IMM;
      MUL, DIV:                              return CLS_MULDIV;
      LD:                                    return CLS_LD;
      ST:                                    return CLS_ST;
      NEG, NOT:                              return CLS_UNARY;
      JR, MFHI, MFLO, IN, OUT:               return CLS_SINGLE;
      NOP:                                   return CLS_NOP;
      HALT:                                  return CLS_HALT;
      default:                               return CLS_ILLEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit_if : IR/memory inputs and datapath control outputs      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface control_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]   ir;
  logic                    mem_ready;
  logic [15:0]             reg_in;
  logic [9:0]              ctrl_in;
  logic [23:0]             bus_sel;
  logic                    mem_read;
  logic                    mem_write;
  logic [OPCODE_WIDTH-1:0] alu_op;
  logic                    run;
  logic                    illegal;

  modport master (
    input  ir, mem_ready,
    output reg_in, ctrl_in, bus_sel, mem_read, mem_write, alu_op, run, illegal
  );

  modport slave (
    output ir, mem_ready,
    input  reg_in, ctrl_in, bus_sel, mem_read, mem_write, alu_op, run, illegal
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_reg_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reg_select : 4-to-16 one-hot decoder with enable                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reg_select (
  input  wire logic [3:0]  sel_i,
  input  wire logic        en_i,
  output logic      [15:0] onehot_o
);
  for (genvar i = 0; i < 16; i++) begin : g_dec
    assign onehot_o[i] = en_i && (sel_i == 4'(i));
  end
endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit : Moore FSM sequencing fetch/execute control steps.     |
// | Define CU_MEM_WAIT_EN to stall memory steps until mem_ready.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 5
) (
  input wire logic         clock,
  input wire logic         clear,
  control_unit_if.master   cu
);

  state_t    state_q, state_d;
  op_class_t w_cls;
  logic [OPCODE_WIDTH-1:0] w_op;
  logic [3:0]  w_ra, w_rb, w_rc, w_gpr_idx;
  logic        w_mem_ok, w_ra_in, w_gpr_out;
  logic [23:0] w_bus;
  logic [15:0] w_gpr_onehot;
  logic        unused_bits;

  assign w_op  = cu.ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign w_ra  = cu.ir[DATA_WIDTH-OPCODE_WIDTH-1 -: 4];
  assign w_rb  = cu.ir[DATA_WIDTH-OPCODE_WIDTH-5 -: 4];
  assign w_rc  = cu.ir[DATA_WIDTH-OPCODE_WIDTH-9 -: 4];
  assign w_cls = op_class(w_op);

`ifdef CU_MEM_WAIT_EN
  assign w_mem_ok    = cu.mem_ready;
  assign unused_bits = ^cu.ir[DATA_WIDTH-OPCODE_WIDTH-13:0];
`else
  assign w_mem_ok    = 1'b1;
  assign unused_bits = ^{cu.mem_ready, cu.ir[DATA_WIDTH-OPCODE_WIDTH-13:0]};
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = w_mem_ok ? S_T2 : S_T1;
      S_T2:    state_d = S_T3;
      S_T3: begin
        case (w_cls)
          CLS_RTYPE, CLS_IMM, CLS_MULDIV,
          CLS_LD, CLS_ST, CLS_UNARY:     state_d = S_T4;
          CLS_HALT:                      state_d = S_HALTED;
          default:                       state_d = S_T0;
        endcase
      end
      S_T4: state_d = (w_cls == CLS_UNARY) ? S_T0 : S_T5;
      S_T5: state_d = (w_cls == CLS_RTYPE || w_cls == CLS_IMM) ? S_T0 : S_T6;
      S_T6: begin
        if (w_cls == CLS_LD)      state_d = w_mem_ok ? S_T7 : S_T6;
        else if (w_cls == CLS_ST) state_d = S_T7;
        else                      state_d = S_T0;
      end
      S_T7: state_d = (w_cls == CLS_ST && !w_mem_ok) ? S_T7 : S_T0;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RESET;
    endcase
  end

  // Exactly one bus source per step: either a non-GPR bit in w_bus or the GPR decoder.
  always_comb begin
    w_bus        = '0;
    cu.ctrl_in   = '0;
    cu.alu_op    = '0;
    cu.mem_read  = 1'b0;
    cu.mem_write = 1'b0;
    cu.illegal   = 1'b0;
    w_ra_in      = 1'b0;
    w_gpr_out    = 1'b0;
    w_gpr_idx    = w_rb;
    case (state_q)
      S_T0: begin
        w_bus[BUS_PC] = 1'b1;
        cu.ctrl_in[CTRL_MARIN] = 1'b1;
        cu.ctrl_in[CTRL_RZIN]  = 1'b1;
        cu.alu_op = OPCODE_WIDTH'(INC);
      end
      S_T1: begin
        w_bus[BUS_ZLO] = 1'b1;
        cu.ctrl_in[CTRL_PCIN]  = 1'b1;
        cu.ctrl_in[CTRL_MDRIN] = 1'b1;
        cu.mem_read = 1'b1;
      end
      S_T2: begin
        w_bus[BUS_MDR] = 1'b1;
        cu.ctrl_in[CTRL_IRIN] = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          CLS_RTYPE, CLS_IMM, CLS_MULDIV, CLS_LD, CLS_ST: begin
            w_gpr_out = 1'b1;
            cu.ctrl_in[CTRL_RYIN] = 1'b1;
          end
          CLS_UNARY: begin
            w_gpr_out = 1'b1;
            cu.alu_op = w_op;
            cu.ctrl_in[CTRL_RZIN] = 1'b1;
          end
          CLS_SINGLE: begin
            case (w_op)
              OPCODE_WIDTH'(MFHI): begin w_bus[BUS_HI] = 1'b1;     w_ra_in = 1'b1; end
              OPCODE_WIDTH'(MFLO): begin w_bus[BUS_LO] = 1'b1;     w_ra_in = 1'b1; end
              OPCODE_WIDTH'(IN):   begin w_bus[BUS_INPORT] = 1'b1; w_ra_in = 1'b1; end
              OPCODE_WIDTH'(OUT): begin
                w_gpr_out = 1'b1; w_gpr_idx = w_ra;
                cu.ctrl_in[CTRL_OUTIN] = 1'b1;
              end
              default: begin
                w_gpr_out = 1'b1; w_gpr_idx = w_ra;
                cu.ctrl_in[CTRL_PCIN] = 1'b1;
              end
            endcase
          end
          CLS_ILLEGAL: cu.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        case (w_cls)
          CLS_RTYPE, CLS_MULDIV: begin
            w_gpr_out = 1'b1; w_gpr_idx = w_rc;
            cu.alu_op = w_op;
            cu.ctrl_in[CTRL_RZIN] = 1'b1;
          end
          CLS_IMM, CLS_LD, CLS_ST: begin
            w_bus[BUS_C] = 1'b1;
            cu.alu_op = (w_cls == CLS_IMM) ? w_op : OPCODE_WIDTH'(ADDI);
            cu.ctrl_in[CTRL_RZIN] = 1'b1;
          end
          CLS_UNARY: begin w_bus[BUS_ZLO] = 1'b1; w_ra_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        w_bus[BUS_ZLO] = 1'b1;
        case (w_cls)
          CLS_RTYPE, CLS_IMM: w_ra_in = 1'b1;
          CLS_MULDIV:         cu.ctrl_in[CTRL_LOIN]  = 1'b1;
          CLS_LD, CLS_ST:     cu.ctrl_in[CTRL_MARIN] = 1'b1;
          default: ;
        endcase
      end
      S_T6: begin
        case (w_cls)
          CLS_MULDIV: begin w_bus[BUS_ZHI] = 1'b1; cu.ctrl_in[CTRL_HIIN] = 1'b1; end
          CLS_LD:     begin cu.mem_read = 1'b1;   cu.ctrl_in[CTRL_MDRIN] = 1'b1; end
          CLS_ST: begin
            w_gpr_out = 1'b1; w_gpr_idx = w_ra;
            cu.ctrl_in[CTRL_MDRIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        if (w_cls == CLS_LD) begin
          w_bus[BUS_MDR] = 1'b1;
          w_ra_in = 1'b1;
        end else if (w_cls == CLS_ST) begin
          cu.mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  reg_select u_ra_dec (
    .sel_i    (w_ra),
    .en_i     (w_ra_in),
    .onehot_o (cu.reg_in)
  );

  reg_select u_bus_dec (
    .sel_i    (w_gpr_idx),
    .en_i     (w_gpr_out),
    .onehot_o (w_gpr_onehot)
  );

  assign cu.bus_sel = w_bus | {8'd0, w_gpr_onehot};
  assign cu.run     = (state_q != S_RESET) && (state_q != S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_unit : scoreboard bench, per-cycle expected control words |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_control_unit;

  typedef struct {
    string       name;
    logic [23:0] bus;
    logic [9:0]  ctrl;
    logic [15:0] rin;
    logic [4:0]  alu;
    logic        mr, mw, run, ill;
  } exp_t;

  logic clock = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  exp_t exp_q[$];

  control_unit_if #(.DATA_WIDTH(32), .OPCODE_WIDTH(5)) cu_if ();

  control_unit #(.DATA_WIDTH(32), .OPCODE_WIDTH(5)) dut (
    .clock (clock),
    .clear (clear),
    .cu    (cu_if)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  task automatic push(input string n, input logic [23:0] bus, input logic [9:0] ctrl,
                      input logic [15:0] rin, input logic [4:0] alu,
                      input logic mr, input logic mw, input logic run, input logic ill);
    exp_t e;
    e.name = n; e.bus = bus; e.ctrl = ctrl; e.rin = rin; e.alu = alu;
    e.mr = mr; e.mw = mw; e.run = run; e.ill = ill;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input string n, input logic [23:0] bus, input logic [9:0] ctrl,
                     input logic [15:0] rin, input logic [4:0] alu,
                     input logic mr, input logic mw, input logic run, input logic ill);
    push(n, bus, ctrl, rin, alu, mr, mw, run, ill);
    @(posedge clock); #1;
  endtask

  task automatic fetch();
    cyc("T0", 24'h100000, 10'h018, 16'h0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("T1", 24'h080000, 10'h022, 16'h0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0);
    cyc("T2", 24'h200000, 10'h001, 16'h0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (cu_if.bus_sel !== e.bus || cu_if.ctrl_in !== e.ctrl || cu_if.reg_in !== e.rin ||
          cu_if.alu_op !== e.alu || cu_if.mem_read !== e.mr || cu_if.mem_write !== e.mw ||
          cu_if.run !== e.run || cu_if.illegal !== e.ill) begin
        errors++;
        $display("FAIL %s @%0t: got bus=%h ctrl=%h reg=%h alu=%0d mr=%b mw=%b run=%b ill=%b, want bus=%h ctrl=%h reg=%h alu=%0d mr=%b mw=%b run=%b ill=%b",
                 e.name, $time, cu_if.bus_sel, cu_if.ctrl_in, cu_if.reg_in, cu_if.alu_op,
                 cu_if.mem_read, cu_if.mem_write, cu_if.run, cu_if.illegal,
                 e.bus, e.ctrl, e.rin, e.alu, e.mr, e.mw, e.run, e.ill);
      end
    end
  end

  always @(negedge clock) begin
    if (mon_on) begin
      checks++;
      if (!$onehot0(cu_if.bus_sel) || !$onehot0(cu_if.reg_in)) begin
        errors++;
        $display("FAIL onehot @%0t: got bus=%h reg=%h, want zero or one-hot",
                 $time, cu_if.bus_sel, cu_if.reg_in);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion, want finish before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1;
    cu_if.ir = 32'd0;
    cu_if.mem_ready = 1'b1;
    #2 clear = 1'b0;
    @(posedge clock); #1;
    mon_on = 1'b1;
    push("reset", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); #1 clear = 1'b1;
    @(posedge clock); #1;

    // ADD R3,R1,R2
    cu_if.ir = mk_ir(5'd0, 4'd3, 4'd1, 4'd2);
    fetch();
    cyc("add_T3", 24'h000002, 10'h004, 16'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("add_T4", 24'h000004, 10'h008, 16'h0,    5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("add_T5", 24'h080000, 10'h000, 16'h0008, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // MUL R4,R5,R6
    cu_if.ir = mk_ir(5'd14, 4'd4, 4'd5, 4'd6);
    fetch();
    cyc("mul_T3", 24'h000020, 10'h004, 16'h0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mul_T4", 24'h000040, 10'h008, 16'h0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mul_T5", 24'h080000, 10'h080, 16'h0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);
    cyc("mul_T6", 24'h040000, 10'h040, 16'h0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);

    // LD R5, C(R2) with a memory stall in T6
    cu_if.ir = mk_ir(5'd11, 4'd5, 4'd2, 4'd0);
    fetch();
    cyc("ld_T3", 24'h000004, 10'h004, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("ld_T4", 24'h800000, 10'h008, 16'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    cu_if.mem_ready = 1'b0;
    cyc("ld_T5", 24'h080000, 10'h010, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CU_MEM_WAIT_EN
    for (int i = 0; i < 3; i++)
      cyc("ld_T6_wait", 24'h0, 10'h020, 16'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
    cu_if.mem_ready = 1'b1;
    cyc("ld_T6", 24'h000000, 10'h020, 16'h0,    5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("ld_T7", 24'h200000, 10'h000, 16'h0020, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ST R7, C(R0)
    cu_if.ir = mk_ir(5'd13, 4'd7, 4'd0, 4'd0);
    fetch();
    cyc("st_T3", 24'h000001, 10'h004, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("st_T4", 24'h800000, 10'h008, 16'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("st_T5", 24'h080000, 10'h010, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("st_T6", 24'h000080, 10'h020, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("st_T7", 24'h000000, 10'h000, 16'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    // NEG R2,R9
    cu_if.ir = mk_ir(5'd16, 4'd2, 4'd9, 4'd0);
    fetch();
    cyc("neg_T3", 24'h000200, 10'h008, 16'h0,    5'd16, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("neg_T4", 24'h080000, 10'h000, 16'h0004, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0);

    cu_if.ir = mk_ir(5'd22, 4'd15, 4'd0, 4'd0);
    fetch();
    cyc("mfhi_T3", 24'h010000, 10'h000, 16'h8000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cu_if.ir = mk_ir(5'd25, 4'd1, 4'd0, 4'd0);
    fetch();
    cyc("out_T3", 24'h000002, 10'h100, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cu_if.ir = mk_ir(5'd24, 4'd0, 4'd0, 4'd0);
    fetch();
    cyc("in_T3", 24'h400000, 10'h000, 16'h0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cu_if.ir = mk_ir(5'd20, 4'd6, 4'd0, 4'd0);
    fetch();
    cyc("jr_T3", 24'h000040, 10'h002, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cu_if.ir = mk_ir(5'd26, 4'd3, 4'd1, 4'd2);
    fetch();
    cyc("nop_T3", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Undefined opcode 30: single-cycle illegal pulse, then straight to T0
    cu_if.ir = mk_ir(5'd30, 4'd3, 4'd1, 4'd2);
    fetch();
    cyc("ill_T3", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    cu_if.ir = mk_ir(5'd27, 4'd0, 4'd0, 4'd0);
    fetch();
    cyc("halt_T3", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("halted", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    clear = 1'b0;
    #1 push("clr_halt", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); #1 clear = 1'b1;
    @(posedge clock); #1;

    // ADD interrupted by clear in the middle of T4
    cu_if.ir = mk_ir(5'd0, 4'd3, 4'd1, 4'd2);
    fetch();
    cyc("add2_T3", 24'h000002, 10'h004, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    clear = 1'b0;
    #1 push("clr_mid", 24'h0, 10'h0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock); #1 clear = 1'b1;
    @(posedge clock); #1;
    cyc("post_T0", 24'h100000, 10'h018, 16'h0, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0);

    @(negedge clock); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
